// File: rtl/beehive_convert_pkg.sv
// Shared definitions for the Beehive <-> AXIS stream adapters.
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 256
`endif
`ifndef MTU_SIZE_W
`define MTU_SIZE_W 16
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 5
`endif

package beehive_convert_pkg;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_IN_FRAME = 1'b1
    } conv_state_e;

    // Frame byte counter width; frames longer than 64 KiB wrap.
    localparam int CNT_W = 16;

    function automatic int ratio(input int axis_w, input int in_w);
        return axis_w / in_w;
    endfunction

    function automatic int in_bytes(input int in_w);
        return in_w / 8;
    endfunction

endpackage

// File: rtl/tx_len_checker.sv
// Frame tracker for the TX adapter: counts accepted bytes per frame, compares
// against the announced size, flags protocol violations, keeps error stats.
//
// state       | meaning
// ST_IDLE     | between frames, next legal beat carries startframe
// ST_IN_FRAME | frame open, waiting for endframe
module tx_len_checker
    import beehive_convert_pkg::*;
#(
    parameter int IN_BYTES  = 32,
    parameter int SIZE_W    = 16,
    parameter int PAD_W     = 5,
    parameter bit CHECK_LEN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              beat_acc,
    input  logic              startframe,
    input  logic              endframe,
    input  logic [SIZE_W-1:0] frame_size,
    input  logic [PAD_W-1:0]  padbytes,
    output logic              frame_bad,
    output logic [15:0]       stat_len_err,
    output logic [15:0]       stat_proto_err
);

    conv_state_e      state, state_next;
    logic [CNT_W-1:0] byte_cnt, size_q, beat_bytes, cnt_next, size_cur;
    logic             proto_sticky, proto_now, len_mis, start_ok;

    assign beat_bytes = CNT_W'(IN_BYTES) - CNT_W'(padbytes);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state: a stray startframe inside a frame does not restart it.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:     if (beat_acc && startframe && !endframe) state_next = ST_IN_FRAME;
            ST_IN_FRAME: if (beat_acc && endframe)                state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Per-beat error decode; length only checked for frames that really started.
    always_comb begin
        start_ok  = (state == ST_IDLE) && startframe;
        proto_now = beat_acc && (((state == ST_IDLE) && !startframe) ||
                                 ((state == ST_IN_FRAME) && startframe));
        cnt_next  = start_ok ? beat_bytes : byte_cnt + beat_bytes;
        size_cur  = start_ok ? CNT_W'(frame_size) : size_q;
        len_mis   = CHECK_LEN && beat_acc && endframe &&
                    ((state == ST_IN_FRAME) || start_ok) && (cnt_next != size_cur);
        frame_bad = proto_now || proto_sticky || len_mis;
    end

    // Byte counter, captured size and sticky protocol error.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt     <= '0;
            size_q       <= '0;
            proto_sticky <= 1'b0;
        end else if (beat_acc) begin
            byte_cnt     <= cnt_next;
            if (start_ok) size_q <= CNT_W'(frame_size);
            proto_sticky <= endframe ? 1'b0 : (proto_sticky || proto_now);
        end
    end

    // Saturating error statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_len_err   <= '0;
            stat_proto_err <= '0;
        end else begin
            if (len_mis && (stat_len_err != 16'hFFFF))     stat_len_err   <= stat_len_err + 16'd1;
            if (proto_now && (stat_proto_err != 16'hFFFF)) stat_proto_err <= stat_proto_err + 16'd1;
        end
    end

endmodule

// File: rtl/beehive_tx_axis_adapter.sv
// Beehive MAC-side TX stream to AXIS: packs RATIO beats per word, registers
// the word, optionally flips byte order, and tags bad frames in tuser[0].
module beehive_tx_axis_adapter
    import beehive_convert_pkg::*;
#(
    parameter int AXIS_SYNC_DATA_WIDTH    = 512,
    parameter int AXIS_SYNC_KEEP_WIDTH    = AXIS_SYNC_DATA_WIDTH / 8,
    parameter int AXIS_SYNC_TX_USER_WIDTH = 1,
    parameter int IN_DATA_W               = `MAC_INTERFACE_W,
    parameter bit FLIP_BYTES              = 1,
    parameter bit CHECK_LEN               = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               src_convert_tx_val,
    input  logic                               src_convert_tx_startframe,
    input  logic [`MTU_SIZE_W-1:0]             src_convert_tx_frame_size,
    input  logic                               src_convert_tx_endframe,
    input  logic [IN_DATA_W-1:0]               src_convert_tx_data,
    input  logic [`MAC_PADBYTES_W-1:0]         src_convert_tx_padbytes,
    output logic                               convert_src_tx_rdy,
    output logic                               app_axis_sync_tx_tvalid,
    output logic [AXIS_SYNC_DATA_WIDTH-1:0]    app_axis_sync_tx_tdata,
    output logic [AXIS_SYNC_KEEP_WIDTH-1:0]    app_axis_sync_tx_tkeep,
    output logic                               app_axis_sync_tx_tlast,
    output logic [AXIS_SYNC_TX_USER_WIDTH-1:0] app_axis_sync_tx_tuser,
    input  logic                               app_axis_sync_tx_tready,
    output logic [31:0]                        stat_frames,
    output logic [15:0]                        stat_len_err,
    output logic [15:0]                        stat_proto_err
);

    localparam int RATIO    = ratio(AXIS_SYNC_DATA_WIDTH, IN_DATA_W);
    localparam int IN_BYTES = in_bytes(IN_DATA_W);
    localparam int IDX_W    = (RATIO > 1) ? $clog2(RATIO) : 1;

    if ((AXIS_SYNC_DATA_WIDTH % IN_DATA_W) != 0) begin : g_bad_ratio
        $error("AXIS_SYNC_DATA_WIDTH must be a multiple of IN_DATA_W");
    end
    if (AXIS_SYNC_TX_USER_WIDTH < 1) begin : g_bad_user
        $error("AXIS_SYNC_TX_USER_WIDTH must be at least 1");
    end
    if (AXIS_SYNC_KEEP_WIDTH * 8 != AXIS_SYNC_DATA_WIDTH) begin : g_bad_keep
        $error("AXIS_SYNC_KEEP_WIDTH must be AXIS_SYNC_DATA_WIDTH/8");
    end

    logic [AXIS_SYNC_DATA_WIDTH-1:0]    asm_data, word_data, out_data;
    logic [AXIS_SYNC_KEEP_WIDTH-1:0]    asm_keep, word_keep, out_keep;
    logic [AXIS_SYNC_TX_USER_WIDTH-1:0] out_user;
    logic [IN_BYTES-1:0]                beat_keep;
    logic [IDX_W-1:0]                   idx;
    logic                               out_valid, out_last;
    logic                               beat_acc, word_done, frame_bad;

    assign convert_src_tx_rdy = !rst && (!out_valid || app_axis_sync_tx_tready);
    assign beat_acc           = src_convert_tx_val && convert_src_tx_rdy;
    assign beat_keep          = {IN_BYTES{1'b1}} << src_convert_tx_padbytes;
    assign word_done          = src_convert_tx_endframe || (idx == IDX_W'(RATIO - 1));

    tx_len_checker #(
        .IN_BYTES  (IN_BYTES),
        .SIZE_W    (`MTU_SIZE_W),
        .PAD_W     (`MAC_PADBYTES_W),
        .CHECK_LEN (CHECK_LEN)
    ) u_len_checker (
        .clk            (clk),
        .rst            (rst),
        .beat_acc       (beat_acc),
        .startframe     (src_convert_tx_startframe),
        .endframe       (src_convert_tx_endframe),
        .frame_size     (src_convert_tx_frame_size),
        .padbytes       (src_convert_tx_padbytes),
        .frame_bad      (frame_bad),
        .stat_len_err   (stat_len_err),
        .stat_proto_err (stat_proto_err)
    );

    // Current assembly word with the incoming beat dropped into slot idx (slot 0 = MSBs).
    always_comb begin
        word_data = asm_data;
        word_keep = asm_keep;
        for (int s = 0; s < RATIO; s++) begin
            if (IDX_W'(s) == idx) begin
                word_data[AXIS_SYNC_DATA_WIDTH-1-s*IN_DATA_W -: IN_DATA_W] = src_convert_tx_data;
                word_keep[AXIS_SYNC_KEEP_WIDTH-1-s*IN_BYTES -: IN_BYTES]   = beat_keep;
            end
        end
    end

    // Assembly register; cleared on completion so unfilled slots leave as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            asm_data <= '0;
            asm_keep <= '0;
            idx      <= '0;
        end else if (beat_acc) begin
            if (word_done) begin
                asm_data <= '0;
                asm_keep <= '0;
                idx      <= '0;
            end else begin
                asm_data <= word_data;
                asm_keep <= word_keep;
                idx      <= idx + 1'b1;
            end
        end
    end

    // Output register; a new word only loads when the previous one is gone.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_user  <= '0;
        end else if (beat_acc && word_done) begin
            out_valid   <= 1'b1;
            out_last    <= src_convert_tx_endframe;
            out_data    <= word_data;
            out_keep    <= word_keep;
            out_user    <= '0;
            out_user[0] <= src_convert_tx_endframe && frame_bad;
        end else if (app_axis_sync_tx_tready) begin
            out_valid <= 1'b0;
        end
    end

    // Optional byte reversal of data and matching bit reversal of keep.
    always_comb begin
        app_axis_sync_tx_tdata = out_data;
        app_axis_sync_tx_tkeep = out_keep;
        if (FLIP_BYTES) begin
            for (int b = 0; b < AXIS_SYNC_KEEP_WIDTH; b++) begin
                app_axis_sync_tx_tdata[8*b +: 8] = out_data[8*(AXIS_SYNC_KEEP_WIDTH-1-b) +: 8];
                app_axis_sync_tx_tkeep[b]        = out_keep[AXIS_SYNC_KEEP_WIDTH-1-b];
            end
        end
    end

    assign app_axis_sync_tx_tvalid = out_valid;
    assign app_axis_sync_tx_tlast  = out_last;
    assign app_axis_sync_tx_tuser  = out_user;

    // Saturating count of frames whose last word handshook.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_frames <= '0;
        end else if (out_valid && app_axis_sync_tx_tready && out_last &&
                     (stat_frames != 32'hFFFF_FFFF)) begin
            stat_frames <= stat_frames + 32'd1;
        end
    end

endmodule
